// File: rtl/anita4_single_scaler.sv
// Per-channel trigger rate scaler: counts rising edges of each channel over a gate period, latches them into hold registers for readout.
// Latency: hold registers update on the terminal-cycle edge; DONE and DATA are registered, DATA follows SEL one cycle later.
// Backpressure: none; ENABLE low freezes counting. SCALER_AUTOMASK_EN adds per-channel threshold masks on MASK_OUT.
module anita4_single_scaler #(
    parameter int NCH   = 8,
    parameter int CNT_W = 16,
    parameter int PER_W = 32,
    parameter int SEL_W = 3
) (
    input  logic             CLK,
    input  logic             CLR_B,
    input  logic [NCH-1:0]   TRIG_IN,
    input  logic [PER_W-1:0] PERIOD,
    input  logic             ENABLE,
    input  logic [SEL_W-1:0] SEL,
    input  logic [CNT_W-1:0] THRESH,
    output logic [CNT_W-1:0] DATA,
    output logic             DONE,
    output logic [NCH-1:0]   MASK_OUT
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               NSEL    = 2 ** SEL_W;

    logic [NCH-1:0]   trig_prev;
    logic [NCH-1:0]   edge_hit;
    logic [CNT_W-1:0] cnt      [NCH];
    logic [CNT_W-1:0] cnt_next [NCH];
    logic [CNT_W-1:0] hold     [NCH];
    logic [CNT_W-1:0] hold_pad [NSEL];
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] per_ld;
    logic [PER_W-1:0] per_lim;
    logic             started;
    logic             terminal;

    // Edge detect, saturating next-count, and terminal-cycle decode.
    // Before the first enabled cycle the load register is stale, so the live PERIOD is compared instead.
    always_comb begin
        edge_hit = TRIG_IN & ~trig_prev & {NCH{ENABLE}};
        per_lim  = started ? per_ld : PERIOD;
        terminal = ENABLE && (per_cnt == per_lim);
        for (int i = 0; i < NCH; i++) begin
            cnt_next[i] = (edge_hit[i] && (cnt[i] != CNT_MAX)) ? cnt[i] + 1'b1 : cnt[i];
        end
    end

    // Gate-period counter; PERIOD is (re)sampled at each period start, DONE marks the cycle after a terminal edge.
    always_ff @(posedge CLK or negedge CLR_B) begin
        if (!CLR_B) begin
            per_cnt <= '0;
            per_ld  <= '0;
            started <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= terminal;
            if (ENABLE) begin
                started <= 1'b1;
                if (!started || terminal) begin
                    per_ld <= PERIOD;
                end
                per_cnt <= terminal ? '0 : per_cnt + 1'b1;
            end
        end
    end

    // Per-channel counters and hold registers; a terminal-cycle edge closes into the ending period.
    always_ff @(posedge CLK or negedge CLR_B) begin
        if (!CLR_B) begin
            trig_prev <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i]  <= '0;
                hold[i] <= '0;
            end
        end else if (ENABLE) begin
            trig_prev <= TRIG_IN;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= terminal ? '0 : cnt_next[i];
                if (terminal) begin
                    hold[i] <= cnt_next[i];
                end
            end
        end
    end

    // Selects beyond the last channel read as zero.
    for (genvar g = 0; g < NSEL; g++) begin : g_pad
        if (g < NCH) begin : g_real
            assign hold_pad[g] = hold[g];
        end else begin : g_zero
            assign hold_pad[g] = '0;
        end
    end

    // Registered readout mux.
    always_ff @(posedge CLK or negedge CLR_B) begin
        if (!CLR_B) begin
            DATA <= '0;
        end else begin
            DATA <= hold_pad[SEL];
        end
    end

`ifdef SCALER_AUTOMASK_EN
    // Auto-mask refreshes with the hold registers and holds until the next update.
    always_ff @(posedge CLK or negedge CLR_B) begin
        if (!CLR_B) begin
            MASK_OUT <= '0;
        end else if (terminal) begin
            for (int i = 0; i < NCH; i++) begin
                MASK_OUT[i] <= (cnt_next[i] > THRESH);
            end
        end
    end
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
    assign MASK_OUT      = '0;
`endif

endmodule

// File: tb/tb_anita4_single_scaler.sv
// Bench for anita4_single_scaler: default-size instance plus a 6-channel, 4-bit instance on shared stimulus.
// Latency: expected hold values queue at stimulus time and are compared with DATA the cycle after DONE.
// Backpressure: none.
module tb_anita4_single_scaler;

    logic        CLK = 1'b0;
    logic        CLR_B = 1'b1;
    logic [7:0]  trig = '0;
    logic [31:0] period = '0;
    logic        enable = 1'b0;
    logic [2:0]  sel = '0;
    logic [15:0] thresh = '0;

    logic [15:0] data;
    logic        done;
    logic [7:0]  mask;
    logic [3:0]  data4;
    logic        done4;
    logic [5:0]  mask4;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int exp4_q[$];
    bit pend = 1'b0;

    always #5 CLK = ~CLK;

    anita4_single_scaler dut (
        .CLK(CLK), .CLR_B(CLR_B), .TRIG_IN(trig), .PERIOD(period), .ENABLE(enable),
        .SEL(sel), .THRESH(thresh), .DATA(data), .DONE(done), .MASK_OUT(mask)
    );

    anita4_single_scaler #(.NCH(6), .CNT_W(4), .PER_W(32), .SEL_W(3)) dut4 (
        .CLK(CLK), .CLR_B(CLR_B), .TRIG_IN(trig[5:0]), .PERIOD(period), .ENABLE(enable),
        .SEL(sel), .THRESH(thresh[3:0]), .DATA(data4), .DONE(done4), .MASK_OUT(mask4)
    );

    typedef struct {
        int per;
        int ch;
        int lvl;
        int npulse;
        int exp;
    } rec_t;

    rec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected hold for the wide instance and the 6-channel/4-bit one.
    task automatic push_exp(input int v, input int ch);
        exp_q.push_back(v);
        exp4_q.push_back((ch < 6) ? ((v > 15) ? 15 : v) : 0);
    endtask

    task automatic do_reset(input string name);
        CLR_B  = 1'b0;
        enable = 1'b0;
        trig   = '0;
        sel    = '0;
        exp_q.delete();
        exp4_q.delete();
        pend   = 1'b0;
        #2;
        chk({name, "_rst_data"}, data, 0);
        chk({name, "_rst_done"}, done, 0);
        chk({name, "_rst_mask"}, mask, 0);
        chk({name, "_rst_data4"}, data4, 0);
        chk({name, "_rst_mask4"}, mask4, 0);
        repeat (2) @(posedge CLK);
        #1;
        CLR_B = 1'b1;
    endtask

    // One clock: drive trig, check DONE, and compare DATA against the scoreboard the cycle after DONE.
    task automatic run_cycle(input logic [7:0] t, input bit exp_done, input string name);
        trig = t;
        tick();
        if (pend) begin
            if (exp_q.size() == 0 || exp4_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_sb: DONE seen with no expected value queued", name);
            end else begin
                chk({name, "_data"}, data, exp_q.pop_front());
                chk({name, "_data4"}, data4, exp4_q.pop_front());
            end
            pend = 1'b0;
        end
        chk({name, "_done"}, done, exp_done);
        chk({name, "_done4"}, done4, exp_done);
        if (done) pend = 1'b1;
    endtask

    function automatic bit pulse_at(input int lvl, input int npulse, input int c);
        int base;
        int k;
        if (lvl > 0 && c >= 1 && c <= lvl) return 1'b1;
        base = (lvl > 0) ? lvl + 2 : 1;
        k = c - base;
        return (k >= 0) && (k % 2 == 0) && (k / 2 < npulse);
    endfunction

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int          p0[6];
        logic [7:0]  t;
        logic [7:0]  onehot;
        logic [2:0]  other;
        logic [7:0]  mask_exp;
        logic [5:0]  mask4_exp;
        bit          prev;

        tbl[0] = '{per: 9,  ch: 0, lvl: 0, npulse: 3,  exp: 3};
        tbl[1] = '{per: 19, ch: 2, lvl: 5, npulse: 2,  exp: 3};
        tbl[2] = '{per: 49, ch: 3, lvl: 0, npulse: 20, exp: 20};
        tbl[3] = '{per: 15, ch: 7, lvl: 0, npulse: 4,  exp: 4};

        #1;
        // Table: one period with pulses, readout of an idle channel, then an empty period.
        for (int r = 0; r < 4; r++) begin
            do_reset($sformatf("tbl%0d", r));
            period = tbl[r].per;
            sel    = tbl[r].ch[2:0];
            enable = 1'b1;
            onehot = 8'b1 << tbl[r].ch;
            other  = 3'(tbl[r].ch + 1);
            push_exp(tbl[r].exp, tbl[r].ch);
            push_exp(0, tbl[r].ch);
            for (int c = 0; c <= 2 * tbl[r].per + 2; c++) begin
                t = (c <= tbl[r].per && pulse_at(tbl[r].lvl, tbl[r].npulse, c)) ? onehot : 8'h00;
                sel = (c == tbl[r].per + 2) ? other : tbl[r].ch[2:0];
                run_cycle(t, (c == tbl[r].per) || (c == 2 * tbl[r].per + 1), $sformatf("tbl%0d_c%0d", r, c));
                if (c == tbl[r].per + 2) begin
                    chk($sformatf("tbl%0d_other_data", r), data, 0);
                    chk($sformatf("tbl%0d_other_data4", r), data4, 0);
                end
            end
        end

        // Pulse in the terminal cycle belongs to the closing period.
        do_reset("term");
        period = 4;
        sel    = 3'd0;
        enable = 1'b1;
        push_exp(2, 0);
        push_exp(1, 0);
        for (int c = 0; c <= 10; c++) begin
            t = (c == 1 || c == 4 || c == 7) ? 8'h01 : 8'h00;
            run_cycle(t, (c == 4) || (c == 9), $sformatf("term_c%0d", c));
        end

        // ENABLE low for 7 cycles: pulses ignored, DONE delayed; then reset mid-period.
        do_reset("ena");
        period = 9;
        sel    = 3'd0;
        push_exp(2, 0);
        for (int c = 0; c <= 17; c++) begin
            enable = !(c >= 3 && c <= 9);
            t = (c == 1 || c == 4 || c == 7 || c == 12 || c == 17) ? 8'h01 : 8'h00;
            run_cycle(t, c == 16, $sformatf("ena_c%0d", c));
        end
        do_reset("midrst");
        period = 9;
        enable = 1'b1;
        push_exp(0, 0);
        for (int c = 0; c <= 10; c++) begin
            run_cycle(8'h00, c == 9, $sformatf("postrst_c%0d", c));
        end

        // PERIOD = 0: every cycle terminal, hold is that cycle's edge bit.
        do_reset("p0");
        p0     = '{1, 0, 1, 1, 0, 0};
        period = 0;
        sel    = 3'd0;
        enable = 1'b1;
        prev   = 1'b0;
        for (int c = 0; c < 6; c++) begin
            push_exp((p0[c] == 1 && !prev) ? 1 : 0, 0);
            prev = (p0[c] == 1);
            run_cycle({7'b0, prev}, 1'b1, $sformatf("p0_c%0d", c));
        end
        do_reset("p0rst");

        // Auto-mask: THRESH = 2, ch0 three pulses, ch1 two pulses.
`ifdef SCALER_AUTOMASK_EN
        mask_exp  = 8'b0000_0001;
        mask4_exp = 6'b00_0001;
`else
        mask_exp  = 8'b0;
        mask4_exp = 6'b0;
`endif
        period = 9;
        thresh = 16'd2;
        sel    = 3'd0;
        enable = 1'b1;
        push_exp(3, 0);
        push_exp(0, 0);
        for (int c = 0; c <= 20; c++) begin
            t = 8'h00;
            if (c == 1 || c == 3 || c == 5) t[0] = 1'b1;
            if (c == 2 || c == 4) t[1] = 1'b1;
            run_cycle(t, (c == 9) || (c == 19), $sformatf("amask_c%0d", c));
            if (c == 5) begin
                chk("amask_pre_mask", mask, 0);
                chk("amask_pre_mask4", mask4, 0);
            end
            if (c == 9) begin
                chk("amask_mask", mask, mask_exp);
                chk("amask_mask4", mask4, mask4_exp);
            end
            if (c == 19) begin
                chk("amask_clear_mask", mask, 0);
                chk("amask_clear_mask4", mask4, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/anita4_single_scaler.md
Name: anita4_single_scaler

Overview:
- Per-channel rate scaler directly downstream of the ANITA4 single-polarisation trigger synchroniser.
- Takes the synchronised oneshot bit (TRIG_SYNC[0]) from each channel and counts rising edges over a programmable gate period.
- At period end, latches all counts into hold registers for slow-control readout.
- Optionally generates per-channel auto-masks that feed the synchroniser MASK inputs.

Parameters:
- NCH, 8, number of trigger channels.
- CNT_W, 16, width of each scaler counter and hold register.
- PER_W, 32, width of the gate-period counter and PERIOD input.
- SEL_W, 3, readout select width; must satisfy 2^SEL_W >= NCH.

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- CLR_B  in  1  asynchronous active-low reset.
- TRIG_IN  in  NCH  per-channel synchronised oneshot (TRIG_SYNC[0] of each synchroniser).
- PERIOD  in  PER_W  gate length in CLK cycles minus 1; sampled at each period start.
- ENABLE  in  1  high = scaler running; low = period counter and scalers frozen.
- SEL  in  SEL_W  channel select for readout.
- THRESH  in  CNT_W  auto-mask threshold (used only with the optional feature).
- DATA  out  CNT_W  hold register of channel SEL, registered.
- DONE  out  1  one-cycle pulse when hold registers update.
- MASK_OUT  out  NCH  auto-mask per channel.

Behaviour:
- Reset (CLR_B low, async): all counters, hold registers, edge-detect registers, period counter, DATA, DONE and MASK_OUT go to 0. Period load register goes to 0.
- Release: the first ENABLE-high cycle loads PERIOD into the period load register and starts period count 0.
- Edge detect: per channel, prev <= TRIG_IN. Increment when TRIG_IN & ~prev. A level held high for N cycles counts once.
- Counters saturate at 2^CNT_W-1; no wrap.
- Period counter: increments each ENABLE-high cycle. When it equals the loaded PERIOD value (terminal cycle), on that clock edge:
  - hold[i] <= counter[i] plus that cycle's edge (saturated);
  - counter[i] <= 0;
  - period counter <= 0;
  - PERIOD is resampled;
  - DONE = 1 for exactly the next cycle.
- An edge arriving in the terminal cycle is counted in the closing period, not the new one.
- PERIOD = 0: every cycle is terminal. DONE stays high continuously and hold[i] equals that cycle's edge bit.
- ENABLE low: counters, period counter and edge registers hold their values. Edges occurring while disabled are not counted. Hold registers and DATA keep their values. DONE is 0.
- Readout: DATA <= hold[SEL], giving one-cycle latency from SEL.
  - SEL >= NCH returns 0.
  - A hold update and a SEL change in the same cycle: DATA reflects the new hold value one cycle later.
- Reset mid-period: everything clears immediately, no DONE pulse, and the partial count is discarded.

Optional Feature:
- Macro: SCALER_AUTOMASK_EN.
- Defined: on each hold update, MASK_OUT[i] <= (new hold[i] > THRESH). MASK_OUT is held until the next update or reset. THRESH = 2^CNT_W-1 never masks.
- Undefined: MASK_OUT is constant 0 and THRESH is unused; no registers are inferred for it.

Test Plan:
- Reset release, PERIOD=9, ENABLE=1; ch0 gets 3 single-cycle pulses, ch1 gets none -> DONE pulses 10 cycles after start; with SEL=0, DATA=3 one cycle later; with SEL=1, DATA=0.
- ch2 held high for 5 cycles, then 2 separate pulses within PERIOD=19 -> hold[2]=3.
- CNT_W=4, 20 pulses on ch3 within one period -> hold[3]=15, no wrap; next period with no pulses -> hold[3]=0.
- Pulse on ch0 exactly in the terminal cycle of PERIOD=4, plus 1 pulse later in the next period -> first hold[0] includes the terminal pulse; second hold[0]=1.
- ENABLE dropped for 7 cycles mid-period with 2 pulses on ch0 during that time -> those pulses are not counted and DONE is delayed by 7 cycles; assert CLR_B low mid-period -> DATA, DONE, MASK_OUT = 0 immediately.
- SCALER_AUTOMASK_EN defined, THRESH=2; ch0=3 pulses, ch1=2 pulses -> MASK_OUT=8'b00000001 after DONE; without the macro -> MASK_OUT stays 0.
